// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: packet-granular round-robin arbiter that merges N transmit
// byte streams into one outbound dataValid/data/newpkt stream. A requester
// owns the output for a whole frame; an inter-frame gap follows each frame,
// and downstream pause stalls byte acceptance without dropping the grant.
module tcp_tx_arbiter #(
   parameter int N   = 2,
   parameter int IFG = 12
) (
   input  logic           CLOCK,
   input  logic           RESET,
   input  logic [N-1:0]   inValid,
   input  logic [8*N-1:0] inData,
   input  logic [N-1:0]   inLast,
   output logic [N-1:0]   inReady,
   input  logic           pause,
   output logic           outDataValid,
   output logic [7:0]     outData,
   output logic           outLast,
   output logic           newpkt,
   output logic [N-1:0]   grant,
   output logic           busy
);

   localparam int PW = (N > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state_reg;
   logic [PW-1:0] ptr_reg;
   logic [7:0]    gapcnt_reg;
   logic          first_reg;
   logic [N-1:0]  grant_reg;
   logic          out_valid_reg;
   logic [7:0]    out_data_reg;
   logic          out_last_reg;
   logic          newpkt_reg;

   logic [7:0]    lane_data [N];
   logic [2*N-1:0] dbl_req;
   logic [N-1:0]  rot_req;
   logic          pick_found;
   logic [PW-1:0] pick_idx;
   int            pick_pos;
   logic          accept;

   // Split the packed lane bus and build the per-lane ready: only the owner
   // may be consumed, and only while the sink is not pausing.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         assign lane_data[gi] = inData[8*gi +: 8];
         assign inReady[gi]   = (state_reg == XFER) & grant_reg[gi] & ~pause;
      end
   endgenerate

   assign accept = |(inValid & inReady);

   // Round-robin search: rotate the requests so the lane after ptr sits at
   // bit 0, then take the lowest set bit and map it back to a lane number.
   assign dbl_req = {inValid, inValid};

   always_comb begin
      rot_req    = N'(dbl_req >> (int'(ptr_reg) + 1));
      pick_found = 1'b0;
      pick_pos   = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot_req[j]) begin
            pick_found = 1'b1;
            pick_pos   = int'(ptr_reg) + 1 + j;
         end
      end
      if (pick_pos >= N) begin
         pick_pos = pick_pos - N;
      end
      pick_idx = PW'(pick_pos);
   end

   // Arbitration FSM with registered output beat; a reset mid-frame simply
   // abandons the frame, so no outLast is ever produced for it.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg     <= IDLE;
         ptr_reg       <= PW'(N - 1);
         gapcnt_reg    <= 8'd0;
         first_reg     <= 1'b0;
         grant_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= 8'h00;
         out_last_reg  <= 1'b0;
         newpkt_reg    <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         newpkt_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  grant_reg <= N'(1) << pick_idx;
                  ptr_reg   <= pick_idx;
                  first_reg <= 1'b1;
                  state_reg <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= lane_data[ptr_reg];
                  out_last_reg  <= inLast[ptr_reg];
                  newpkt_reg    <= first_reg;
                  first_reg     <= 1'b0;
                  if (inLast[ptr_reg]) begin
                     grant_reg <= '0;
                     if (IFG == 0) begin
                        state_reg <= IDLE;
                     end else begin
                        gapcnt_reg <= 8'(IFG);
                        state_reg  <= GAP;
                     end
                  end
               end
            end
            GAP: begin
               // The gap counts down even while paused: it is wire time,
               // not a count of accepted bytes.
               gapcnt_reg <= gapcnt_reg - 8'd1;
               if (gapcnt_reg == 8'd1) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign outDataValid = out_valid_reg;
   assign outData      = out_data_reg;
   assign outLast      = out_last_reg;
   assign newpkt       = newpkt_reg;
   assign grant        = grant_reg;
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Testbench for tcp_tx_arbiter: directed frames per requester lane, expected
// beats queued when each stimulus is issued, and an independent monitor that
// pops and compares every output beat (data, flags, owner, spacing).
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        pause = 1'b0;
   logic [1:0]  inValid;
   logic [15:0] inData;
   logic [1:0]  inLast;
   logic [1:0]  inReady;
   logic        outDataValid;
   logic [7:0]  outData;
   logic        outLast;
   logic        newpkt;
   logic [1:0]  grant;
   logic        busy;

   logic        lane_v [2];
   logic [7:0]  lane_d [2];
   logic        lane_l [2];
   logic        abort = 1'b0;

   // second instance with no inter-frame gap
   logic [1:0]  b_v = 2'b00;
   logic [15:0] b_d = 16'h0000;
   logic [1:0]  b_l = 2'b00;
   logic [1:0]  b_ready;
   logic        b_pause = 1'b0;
   logic        b_odv;
   logic [7:0]  b_od;
   logic        b_ol;
   logic        b_np;
   logic [1:0]  b_gr;
   logic        b_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int prev_cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       first;
      logic [1:0] gnt;
      int         delta;
      int         abs_cyc;
   } exp_t;

   exp_t exp_q[$];

   assign inValid = {lane_v[1], lane_v[0]};
   assign inData  = {lane_d[1], lane_d[0]};
   assign inLast  = {lane_l[1], lane_l[0]};

   tcp_tx_arbiter #(.N(2), .IFG(12)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .inValid(inValid), .inData(inData),
      .inLast(inLast), .inReady(inReady), .pause(pause),
      .outDataValid(outDataValid), .outData(outData), .outLast(outLast),
      .newpkt(newpkt), .grant(grant), .busy(busy)
   );

   tcp_tx_arbiter #(.N(2), .IFG(0)) dut0gap (
      .CLOCK(CLOCK), .RESET(RESET), .inValid(b_v), .inData(b_d),
      .inLast(b_l), .inReady(b_ready), .pause(b_pause),
      .outDataValid(b_odv), .outData(b_od), .outLast(b_ol),
      .newpkt(b_np), .grant(b_gr), .busy(b_busy)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // queue the beats a frame should produce, in output order
   task automatic push_frame(input logic [1:0] src, input logic [7:0] base, input int len,
                             input int npush, input int first_delta, input int first_abs,
                             input int last_abs, input int pause_idx, input int pause_len,
                             input int bub_idx, input int bub_len);
      exp_t e;
      for (int k = 0; k < npush; k++) begin
         e.data    = base + 8'(k);
         e.last    = (k == len - 1);
         e.first   = (k == 0);
         e.gnt     = src;
         e.delta   = (k == 0) ? first_delta :
                     (k == pause_idx) ? pause_len + 1 :
                     (k == bub_idx) ? bub_len + 1 : 1;
         e.abs_cyc = (k == 0) ? first_abs : ((k == len - 1) ? last_abs : -1);
         exp_q.push_back(e);
      end
   endtask

   // present one frame on a lane, holding each byte until it is consumed
   task automatic send_frame(input int lane, input int len, input logic [7:0] base,
                             input int pause_idx, input int pause_len,
                             input int bub_idx, input int bub_len);
      logic acc;
      int   pcnt;
      int   budget;
      logic pause_on;
      for (int k = 0; k < len; k++) begin
         if (abort) break;
         if (k == bub_idx && bub_len > 0) begin
            lane_v[lane] = 1'b0;
            repeat (bub_len) begin
               @(posedge CLOCK);
               #1;
            end
         end
         lane_v[lane] = 1'b1;
         lane_d[lane] = base + 8'(k);
         lane_l[lane] = (k == len - 1);
         pause_on = 1'b0;
         pcnt = 0;
         if (k == pause_idx && pause_len > 0) begin
            pause = 1'b1;
            pause_on = 1'b1;
         end
         acc = 1'b0;
         budget = 0;
         while (!acc) begin
            @(negedge CLOCK);
            acc = inReady[lane];
            @(posedge CLOCK);
            #1;
            if (pause_on) begin
               pcnt++;
               if (pcnt >= pause_len) begin
                  pause = 1'b0;
                  pause_on = 1'b0;
               end
            end
            if (abort) break;
            budget++;
            if (budget > 500) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: lane %0d byte %0d never consumed, required consume", lane, k);
               break;
            end
         end
         if (budget > 500) break;
      end
      lane_v[lane] = 1'b0;
      lane_l[lane] = 1'b0;
   endtask

   task automatic send_frames(input int lane, input int nframes, input int len, input logic [7:0] base0);
      for (int f = 0; f < nframes; f++) begin
         send_frame(lane, len, base0 + 8'(f * 16), -1, 0, -1, 0);
      end
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge CLOCK);
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      repeat (20) @(negedge CLOCK);
   endtask

   task automatic do_reset();
      @(posedge CLOCK);
      #1;
      RESET = 1'b1;
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      chk("reset_outputs", {16'h0, outDataValid, outData, outLast, newpkt, grant, busy, inReady}, 32'd0);
      chk("reset_outputs_ifg0", {16'h0, b_odv, b_od, b_ol, b_np, b_gr, b_busy, b_ready}, 32'd0);
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
   endtask

   // monitor: every output beat is matched against the head of the queue
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK);
         if (!RESET && outDataValid) begin
            $display("beat cyc=%0d data=%02h last=%0b newpkt=%0b grant=%b", cyc, outData, outLast, newpkt, grant);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %02h last %0b, required no beat", outData, outLast);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 32'(outData), 32'(e.data));
               chk("beat_last", 32'(outLast), 32'(e.last));
               chk("beat_newpkt", 32'(newpkt), 32'(e.first));
               chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
               if (!e.last) chk("beat_grant", 32'(grant), 32'(e.gnt));
               if (e.delta > 0) chk("beat_spacing", 32'(cyc - prev_cyc), 32'(e.delta));
               if (e.abs_cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(e.abs_cyc));
            end
            prev_cyc = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      lane_v[0] = 1'b0; lane_v[1] = 1'b0;
      lane_d[0] = 8'h00; lane_d[1] = 8'h00;
      lane_l[0] = 1'b0; lane_l[1] = 1'b0;

      // single 60-byte frame from requester 0
      do_reset();
      @(posedge CLOCK);
      #1;
      t0 = cyc;
      push_frame(2'b01, 8'h00, 60, 60, -1, t0 + 2, t0 + 61, -1, 0, -1, 0);
      fork
         send_frame(0, 60, 8'h00, -1, 0, -1, 0);
      join_none
      while (cyc < t0 + 72) @(negedge CLOCK);
      chk("busy_in_gap", 32'(busy), 32'd1);
      @(negedge CLOCK);
      chk("busy_after_gap", 32'(busy), 32'd0);
      wait_drain(200);

      // contention: both lanes request together, requester 0 wins first
      do_reset();
      push_frame(2'b01, 8'hA0, 4, 4, -1, -1, -1, -1, 0, -1, 0);
      push_frame(2'b10, 8'hB0, 4, 4, 14, -1, -1, -1, 0, -1, 0);
      fork
         send_frame(0, 4, 8'hA0, -1, 0, -1, 0);
         send_frame(1, 4, 8'hB0, -1, 0, -1, 0);
      join_none
      wait_drain(200);

      // fairness: continuous 3-byte frames from both lanes alternate
      do_reset();
      for (int f = 0; f < 4; f++) begin
         push_frame(2'b01, 8'h00 + 8'(f * 16), 3, 3, (f == 0) ? -1 : 14, -1, -1, -1, 0, -1, 0);
         push_frame(2'b10, 8'h80 + 8'(f * 16), 3, 3, 14, -1, -1, -1, 0, -1, 0);
      end
      fork
         send_frames(0, 4, 3, 8'h00);
         send_frames(1, 4, 3, 8'h80);
      join_none
      wait_drain(400);

      // pause for 5 cycles at byte 4, source bubble of 2 cycles at byte 7
      do_reset();
      push_frame(2'b01, 8'h00, 10, 10, -1, -1, -1, 4, 5, 7, 2);
      fork
         send_frame(0, 10, 8'h00, 4, 5, 7, 2);
      join_none
      wait_drain(200);

      // reset after byte 3 of an 8-byte frame truncates it
      do_reset();
      @(posedge CLOCK);
      #1;
      t0 = cyc;
      push_frame(2'b01, 8'h40, 8, 4, -1, t0 + 2, -1, -1, 0, -1, 0);
      fork
         send_frame(0, 8, 8'h40, -1, 0, -1, 0);
      join_none
      while (cyc < t0 + 5) @(negedge CLOCK);
      RESET = 1'b1;
      abort = 1'b1;
      @(negedge CLOCK);
      chk("midframe_reset_outputs", {16'h0, outDataValid, outData, outLast, newpkt, grant, busy, inReady}, 32'd0);
      repeat (2) @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      abort = 1'b0;
      chk("truncated_pending", 32'(exp_q.size()), 32'd0);
      push_frame(2'b01, 8'hC0, 2, 2, -1, -1, -1, -1, 0, -1, 0);
      push_frame(2'b10, 8'hD0, 2, 2, 14, -1, -1, -1, 0, -1, 0);
      fork
         send_frame(0, 2, 8'hC0, -1, 0, -1, 0);
         send_frame(1, 2, 8'hD0, -1, 0, -1, 0);
      join_none
      wait_drain(200);

      // single-byte frame on requester 1 with no inter-frame gap
      @(posedge CLOCK);
      #1;
      b_v = 2'b10;
      b_d = 16'h2000;
      b_l = 2'b10;
      @(negedge CLOCK);
      chk("ifg0_idle_ready", 32'(b_ready), 32'd0);
      @(negedge CLOCK);
      chk("ifg0_grant", 32'(b_gr), 32'h2);
      chk("ifg0_ready", 32'(b_ready), 32'h2);
      @(posedge CLOCK);
      #1;
      b_v = 2'b00;
      b_l = 2'b00;
      @(negedge CLOCK);
      $display("beat ifg0 cyc=%0d data=%02h last=%0b newpkt=%0b", cyc, b_od, b_ol, b_np);
      chk("ifg0_beat", {21'h0, b_odv, b_od, b_np, b_ol}, {21'h0, 1'b1, 8'h20, 1'b1, 1'b1});
      chk("ifg0_idle_busy", 32'(b_busy), 32'd0);
      chk("ifg0_idle_grant", 32'(b_gr), 32'd0);
      @(negedge CLOCK);
      chk("ifg0_no_second_beat", 32'(b_odv), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
